// File: rtl/reorder_in_arb.sv
// Round-robin packet arbiter with sequential packet-ID allocation and credit throttling for the reorder buffer.
// Optional protocol checking (SOP inside a locked packet, spurious retire) is enabled by REORDER_ARB_ERR_EN.
module reorder_in_arb #(
  parameter int NUM_SRC    = 4,
  parameter int PKT_NUM    = 16,
  parameter int DATA_WIDTH = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_vld,
  input  logic [NUM_SRC-1:0]            src_sop,
  input  logic [NUM_SRC-1:0]            src_eop,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]            src_rdy,
  input  logic                          retire_vld,
  output logic                          vld_out,
  output logic                          SOP_out,
  output logic                          EOP_out,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic [$clog2(PKT_NUM)-1:0]    pkt_id_out,
  output logic [$clog2(PKT_NUM):0]      credits,
  output logic                          err_out
);
  localparam int SW = $clog2(NUM_SRC);
  localparam int IW = $clog2(PKT_NUM);
  localparam int CW = IW + 1;

  typedef enum logic [0:0] {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t          state_r;
  logic [SW-1:0]   lock_src_r;
  logic [SW-1:0]   rr_ptr_r;
  logic [IW-1:0]   next_id_r;
  logic [IW-1:0]   cur_id_r;
  logic [CW-1:0]   outstanding_r;
  logic            gap_r;

  logic [NUM_SRC-1:0]    elig_s;
  logic                  grant_vld_s;
  logic [SW-1:0]         grant_idx_s;
  logic [SW-1:0]         sel_src_s;
  logic                  accept_s;
  logic                  sel_sop_s;
  logic                  sel_eop_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic                  proto_err_s;
  logic                  retire_err_s;
  logic                  pkt_end_s;
  logic                  ret_s;
  int                    idx_s;

  // Cyclic first-eligible search starting at rr_ptr; gap_r holds off arbitration for one cycle after a locked packet ends.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    idx_s       = 0;
    elig_s      = src_vld & src_sop &
                  {NUM_SRC{(state_r == IDLE) && !gap_r && (outstanding_r < CW'(PKT_NUM))}};
    for (int k = 0; k < NUM_SRC; k++) begin
      idx_s = int'(rr_ptr_r) + k;
      if (idx_s >= NUM_SRC) begin
        idx_s = idx_s - NUM_SRC;
      end else begin
        idx_s = idx_s;
      end
      if (!grant_vld_s && elig_s[idx_s]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = SW'(idx_s);
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // Ready generation and selection of the beat being forwarded this cycle.
  always_comb begin
    src_rdy   = '0;
    sel_src_s = grant_idx_s;
    case (state_r)
      IDLE: begin
        if (grant_vld_s) begin
          src_rdy[grant_idx_s] = 1'b1;
        end else begin
          src_rdy = '0;
        end
      end
      LOCK: begin
        sel_src_s           = lock_src_r;
        src_rdy[lock_src_r] = 1'b1;
      end
      default: src_rdy = '0;
    endcase
    accept_s   = src_vld[sel_src_s] & src_rdy[sel_src_s];
    sel_sop_s  = src_sop[sel_src_s];
    sel_eop_s  = src_eop[sel_src_s];
    sel_data_s = src_data[int'(sel_src_s)*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef REORDER_ARB_ERR_EN
  assign proto_err_s  = (state_r == LOCK) && accept_s && sel_sop_s;
  assign retire_err_s = retire_vld && (outstanding_r == '0);
`else
  assign proto_err_s  = 1'b0;
  assign retire_err_s = 1'b0;
`endif

  assign pkt_end_s = accept_s && (sel_eop_s || proto_err_s);
  assign ret_s     = retire_vld && (outstanding_r != '0);
  assign credits   = CW'(PKT_NUM) - outstanding_r;

  // Arbitration FSM, ID allocation, outstanding accounting and registered beat outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      lock_src_r    <= '0;
      rr_ptr_r      <= '0;
      next_id_r     <= '0;
      cur_id_r      <= '0;
      outstanding_r <= '0;
      gap_r         <= 1'b0;
      vld_out       <= 1'b0;
      SOP_out       <= 1'b0;
      EOP_out       <= 1'b0;
      data_out      <= '0;
      pkt_id_out    <= '0;
      err_out       <= 1'b0;
    end else begin
      vld_out    <= accept_s;
      SOP_out    <= accept_s && (state_r == IDLE);
      EOP_out    <= pkt_end_s;
      data_out   <= accept_s ? sel_data_s : '0;
      pkt_id_out <= !accept_s ? '0 : ((state_r == IDLE) ? next_id_r : cur_id_r);
      err_out    <= err_out | proto_err_s | retire_err_s;
      gap_r      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_vld_s) begin
            cur_id_r  <= next_id_r;
            next_id_r <= next_id_r + 1'b1;
            rr_ptr_r  <= (grant_idx_s == SW'(NUM_SRC-1)) ? '0 : grant_idx_s + 1'b1;
            if (!sel_eop_s) begin
              state_r    <= LOCK;
              lock_src_r <= grant_idx_s;
            end
          end
        end
        LOCK: begin
          if (pkt_end_s) begin
            state_r <= IDLE;
            gap_r   <= 1'b1;
          end
        end
        default: state_r <= IDLE;
      endcase
      if (grant_vld_s && !ret_s) begin
        outstanding_r <= outstanding_r + CW'(1);
      end else if (!grant_vld_s && ret_s) begin
        outstanding_r <= outstanding_r - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_reorder_in_arb.sv
// Scoreboard bench for reorder_in_arb: per-source beat queues drive the DUT, expected output beats are queued per cycle.
module tb_reorder_in_arb;
  localparam int NUM_SRC = 4;
  localparam int PKT_NUM = 16;
  localparam int DW      = 1;
`ifdef REORDER_ARB_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_SRC-1:0]     src_vld, src_sop, src_eop, src_rdy;
  logic [NUM_SRC*DW-1:0]  src_data;
  logic                   retire_vld;
  logic                   vld_out, SOP_out, EOP_out;
  logic [DW-1:0]          data_out;
  logic [3:0]             pkt_id_out;
  logic [4:0]             credits;
  logic                   err_out;

  typedef logic [2:0] beat_t;   // {sop, eop, data}
  beat_t       src_q [NUM_SRC][$];
  logic [7:0]  exp_q [$];       // {vld, sop, eop, data, id}
  int          n_checks = 0;
  int          n_errors = 0;

  reorder_in_arb #(.NUM_SRC(NUM_SRC), .PKT_NUM(PKT_NUM), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .src_vld(src_vld), .src_sop(src_sop), .src_eop(src_eop),
    .src_data(src_data), .src_rdy(src_rdy), .retire_vld(retire_vld), .vld_out(vld_out),
    .SOP_out(SOP_out), .EOP_out(EOP_out), .data_out(data_out), .pkt_id_out(pkt_id_out),
    .credits(credits), .err_out(err_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] ob(input logic v, input logic s, input logic e, input logic d,
                                    input int id);
    logic [3:0] idv;
    idv = id[3:0];
    return {v, s, e, d, idv};
  endfunction

  function automatic beat_t mk(input logic s, input logic e, input logic d);
    return {s, e, d};
  endfunction

  // One clock: present queue heads, record handshakes, pop accepted beats, compare against scoreboard.
  task automatic step(input logic ret);
    logic [NUM_SRC-1:0] acc;
    logic [7:0]         e;
    @(negedge clk);
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_q[i].size() != 0) begin
        src_vld[i] = 1'b1;
        {src_sop[i], src_eop[i], src_data[i]} = src_q[i][0];
      end else begin
        src_vld[i] = 1'b0;
        {src_sop[i], src_eop[i], src_data[i]} = 3'b000;
      end
    end
    retire_vld = ret;
    #1 acc = src_vld & src_rdy;
    @(posedge clk);
    #1;
    retire_vld = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (acc[i]) void'(src_q[i].pop_front());
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("beat", {24'd0, vld_out, SOP_out, EOP_out, data_out, pkt_id_out}, {24'd0, e});
    end
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b0);
    check("drain", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) src_q[i].delete();
    exp_q.delete();
    src_vld = '0; src_sop = '0; src_eop = '0; src_data = '0; retire_vld = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    src_vld = '0; src_sop = '0; src_eop = '0; src_data = '0; retire_vld = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_vld", vld_out, 0);
    check("rst_sop_eop", {SOP_out, EOP_out}, 0);
    check("rst_data_id", {data_out, pkt_id_out}, 0);
    check("rst_credits", credits, 16);
    check("rst_err", err_out, 0);
    rst = 1'b0;

    // Asynchronous reset in the middle of a packet from source 0
    src_q[0].push_back(mk(1, 0, 1));
    src_q[0].push_back(mk(0, 0, 0));
    src_q[0].push_back(mk(0, 1, 1));
    exp_q.push_back(ob(1, 1, 0, 1, 0));
    exp_q.push_back(ob(1, 0, 0, 0, 0));
    step(1'b0);
    step(1'b0);
    check("pre_rst_credits", credits, 15);
    #2 rst = 1'b1;
    #1;
    check("async_rst_vld", vld_out, 0);
    check("async_rst_credits", credits, 16);
    do_reset();
    src_q[0].push_back(mk(1, 1, 0));
    exp_q.push_back(ob(1, 1, 1, 0, 0));
    run(1);

    // Round-robin of 3-beat packets with one idle output cycle after each
    do_reset();
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int b = 0; b < 3; b++) src_q[s].push_back(mk(b == 0, b == 2, 1'((s + b) & 1)));
    end
    for (int b = 0; b < 3; b++) src_q[0].push_back(mk(b == 0, b == 2, 1'(b & 1)));
    for (int p = 0; p < 5; p++) begin
      for (int b = 0; b < 3; b++)
        exp_q.push_back(ob(1, b == 0, b == 2, 1'(((p % 4) + b) & 1), p));
      exp_q.push_back(8'h00);
    end
    run(20);
    check("rr_credits", credits, 11);

    // Single-beat packets from source 2 every cycle
    do_reset();
    for (int k = 0; k < 6; k++) begin
      src_q[2].push_back(mk(1, 1, 1'(k & 1)));
      exp_q.push_back(ob(1, 1, 1, 1'(k & 1), k));
    end
    run(6);
    check("sb_credits", credits, 10);

    // Credit exhaustion, then one retire releases exactly one grant with ID wrap
    do_reset();
    for (int k = 0; k < 17; k++) src_q[0].push_back(mk(1, 1, 1'(k & 1)));
    for (int k = 0; k < 16; k++) exp_q.push_back(ob(1, 1, 1, 1'(k & 1), k));
    exp_q.push_back(8'h00);
    run(17);
    check("full_credits", credits, 0);
    check("full_rdy", src_rdy, 0);
    exp_q.push_back(8'h00);
    step(1'b1);
    check("retire_credits", credits, 1);
    exp_q.push_back(ob(1, 1, 1, 0, 0));
    step(1'b0);
    check("wrap_credits", credits, 0);
    check("wrap_drain", exp_q.size(), 0);

    // Allocation and retire in the same cycle, then retire at zero outstanding
    do_reset();
    src_q[3].push_back(mk(1, 1, 1));
    exp_q.push_back(ob(1, 1, 1, 1, 0));
    step(1'b0);
    check("sim_credits0", credits, 15);
    src_q[3].push_back(mk(1, 1, 0));
    exp_q.push_back(ob(1, 1, 1, 0, 1));
    step(1'b1);
    check("sim_credits1", credits, 15);
    step(1'b1);
    check("sim_credits2", credits, 16);
    check("sim_err0", err_out, 0);
    step(1'b1);
    check("zero_ret_credits", credits, 16);
    check("zero_ret_err", err_out, 32'(ERR_EN));

    // SOP inside a locked packet from source 1
    do_reset();
    src_q[1].push_back(mk(1, 0, 1));
    src_q[1].push_back(mk(1, 0, 0));
    src_q[1].push_back(mk(1, 1, 1));
    exp_q.push_back(ob(1, 1, 0, 1, 0));
    if (ERR_EN) begin
      exp_q.push_back(ob(1, 0, 1, 0, 0));
      exp_q.push_back(8'h00);
      exp_q.push_back(ob(1, 1, 1, 1, 1));
    end else begin
      exp_q.push_back(ob(1, 0, 0, 0, 0));
      exp_q.push_back(ob(1, 0, 1, 1, 0));
      exp_q.push_back(8'h00);
    end
    run(4);
    check("proto_err", err_out, 32'(ERR_EN));
    check("proto_credits", credits, ERR_EN ? 14 : 15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
